// File: rtl/obi_interconnect_pkg.sv
// Shared OBI interconnect constants and helpers used by the selector and the response router.
package obi_interconnect_pkg;

  localparam int OBI_DATA_W = 32;
  localparam int OBI_ADDR_W = 32;

  // A single master still needs a one-bit index so the ID FIFO has a real width.
  function automatic int idx_width(input int masters);
    return (masters == 1) ? 1 : $clog2(masters);
  endfunction

endpackage

// File: rtl/obi_interconnect_rsp_router_if.sv
// Bus bundle between the per-slave response router and the interconnect (optional err_o under OBI_RSP_ROUTER_ERR_EN).
interface obi_interconnect_rsp_router_if
  import obi_interconnect_pkg::*;
#(
  parameter int MASTERS     = 3,
  parameter int OUTSTANDING = 2
);

  localparam int MASTER_BITS = idx_width(MASTERS);
  localparam int CNT_W       = $clog2(OUTSTANDING + 1);

  logic [MASTER_BITS-1:0]                master_sel_int_i;
  logic                                  slave_req_i;
  logic                                  slave_gnt_i;
  logic                                  slave_rvalid_i;
  logic [OBI_DATA_W-1:0]                 slave_rdata_i;
  logic [MASTERS-1:0]                    master_rvalid_o;
  logic [MASTERS-1:0][OBI_DATA_W-1:0]    master_rdata_o;
  logic                                  req_stall_o;
  logic [CNT_W-1:0]                      outstanding_o;
`ifdef OBI_RSP_ROUTER_ERR_EN
  logic                                  err_o;
`endif

  modport slave (
    input  master_sel_int_i, slave_req_i, slave_gnt_i, slave_rvalid_i, slave_rdata_i,
`ifdef OBI_RSP_ROUTER_ERR_EN
    output err_o,
`endif
    output master_rvalid_o, master_rdata_o, req_stall_o, outstanding_o
  );

  modport master (
    output master_sel_int_i, slave_req_i, slave_gnt_i, slave_rvalid_i, slave_rdata_i,
`ifdef OBI_RSP_ROUTER_ERR_EN
    input  err_o,
`endif
    input  master_rvalid_o, master_rdata_o, req_stall_o, outstanding_o
  );

endinterface

// File: rtl/obi_id_fifo.sv
// Small circular FIFO with push/pop/count/full/empty; holds owner IDs of in-flight transactions.
module obi_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Explicit wrap keeps DEPTH==1 correct where the pointer has a spare bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= wdata;
        wptr      <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/obi_interconnect_rsp_router.sv
// Per-slave OBI response router: remembers grant owners in order and steers rvalid/rdata back to them.
// Optional sticky protocol-error flag err_o is built when OBI_RSP_ROUTER_ERR_EN is defined.
module obi_interconnect_rsp_router
  import obi_interconnect_pkg::*;
#(
  parameter int MASTERS     = 3,
  parameter int OUTSTANDING = 2,
  parameter int MASTER_BITS = idx_width(MASTERS)
) (
  input logic clk_i,
  input logic rst_ni,
  obi_interconnect_rsp_router_if.slave bus
);

  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [MASTER_BITS-1:0] head;
  logic [CNT_W-1:0]       count;

  // Stall is a pure decode of the registered count, so a same-cycle pop never lets a new grant through.
  assign push = bus.slave_req_i & bus.slave_gnt_i & ~full;
  assign pop  = bus.slave_rvalid_i & ~empty;

  obi_id_fifo #(
    .WIDTH (MASTER_BITS),
    .DEPTH (OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .wdata  (bus.master_sel_int_i),
    .rdata  (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign bus.req_stall_o   = full;
  assign bus.outstanding_o = count;

  always_comb begin
    bus.master_rvalid_o = '0;
    bus.master_rdata_o  = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (pop && (head == MASTER_BITS'(m))) begin
        bus.master_rvalid_o[m] = 1'b1;
        bus.master_rdata_o[m]  = bus.slave_rdata_i;
      end
    end
  end

`ifdef OBI_RSP_ROUTER_ERR_EN
  logic violation;
  logic err;

  assign violation = (bus.slave_rvalid_i & empty) | (bus.slave_gnt_i & full);
  assign bus.err_o = err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err <= 1'b0;
    else if (violation) err <= 1'b1;
  end

  no_protocol_violation: assert property (@(posedge clk_i) disable iff (!rst_ni) !violation);
`endif

endmodule

// File: tb/tb_obi_interconnect_rsp_router.sv
// Directed plus randomized bench for the OBI response router, checked against a queue-based owner model.
module tb_obi_interconnect_rsp_router;
  import obi_interconnect_pkg::*;

  localparam int MASTERS     = 3;
  localparam int OUTSTANDING = 2;
  localparam int MB          = idx_width(MASTERS);

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   owner_q[$];
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  obi_interconnect_rsp_router_if #(.MASTERS(MASTERS), .OUTSTANDING(OUTSTANDING)) bus ();

  obi_interconnect_rsp_router #(.MASTERS(MASTERS), .OUTSTANDING(OUTSTANDING)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, checks combinational outputs mid-cycle, then advances the model at the edge.
  task automatic applyStimulus(input logic req, input logic gnt, input int sel,
                               input logic rvalid, input logic [31:0] rdata);
    logic [MASTERS-1:0]                 exp_rv;
    logic [MASTERS-1:0][OBI_DATA_W-1:0] exp_rd;
    bit                                 stall;
    bit                                 pop;
    bus.slave_req_i      = req;
    bus.slave_gnt_i      = gnt;
    bus.master_sel_int_i = MB'(sel);
    bus.slave_rvalid_i   = rvalid;
    bus.slave_rdata_i    = rdata;
    #1;
    stall  = (owner_q.size() == OUTSTANDING);
    pop    = rvalid && (owner_q.size() != 0);
    exp_rv = '0;
    exp_rd = '0;
    if (pop) begin
      exp_rv[owner_q[0]] = 1'b1;
      exp_rd[owner_q[0]] = rdata;
    end
    checkOutput("rvalid", 128'(bus.master_rvalid_o), 128'(exp_rv));
    checkOutput("rdata", 128'(bus.master_rdata_o), 128'(exp_rd));
    checkOutput("stall", 128'(bus.req_stall_o), 128'(stall));
    checkOutput("outstanding", 128'(bus.outstanding_o), 128'(owner_q.size()));
`ifdef OBI_RSP_ROUTER_ERR_EN
    checkOutput("err", 128'(bus.err_o), 128'(exp_err));
`endif
    @(posedge clk);
    if ((rvalid && owner_q.size() == 0) || (gnt && stall)) exp_err = 1'b1;
    if (pop) void'(owner_q.pop_front());
    if (req && gnt && !stall) owner_q.push_back(sel);
    @(negedge clk);
  endtask

  // Asserts reset for one cycle with a late response on the bus; everything must clear at once.
  task automatic resetMidFlight();
    bus.slave_rvalid_i = 1'b1;
    bus.slave_rdata_i  = 32'hBAD0_0001;
    rst_n = 1'b0;
    #1;
    owner_q.delete();
    exp_err = 1'b0;
    checkOutput("rst_outstanding", 128'(bus.outstanding_o), 128'(0));
    checkOutput("rst_stall", 128'(bus.req_stall_o), 128'(0));
    checkOutput("rst_rvalid", 128'(bus.master_rvalid_o), 128'(0));
`ifdef OBI_RSP_ROUTER_ERR_EN
    checkOutput("rst_err", 128'(bus.err_o), 128'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.slave_req_i      = 1'b0;
    bus.slave_gnt_i      = 1'b0;
    bus.master_sel_int_i = '0;
    bus.slave_rvalid_i   = 1'b0;
    bus.slave_rdata_i    = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outstanding", 128'(bus.outstanding_o), 128'(0));
    checkOutput("reset_stall", 128'(bus.req_stall_o), 128'(0));
    checkOutput("reset_rvalid", 128'(bus.master_rvalid_o), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single read");
    applyStimulus(1, 1, 2, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 0, 32'h0);

    $display("[TB] pipelined grants");
    applyStimulus(1, 1, 1, 0, 32'h0);
    applyStimulus(1, 1, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'hAAAA_0001);
    applyStimulus(0, 0, 0, 1, 32'hBBBB_0002);

    $display("[TB] full with pop and grant together");
    applyStimulus(1, 1, 2, 0, 32'h0);
    applyStimulus(1, 1, 1, 0, 32'h0);
    applyStimulus(1, 1, 0, 1, 32'hCCCC_0003);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'hDDDD_0004);

    $display("[TB] steady push and pop");
    applyStimulus(1, 1, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, (i + 1) % MASTERS, 1, $urandom);
    applyStimulus(0, 0, 0, 1, 32'h1234_5678);

    $display("[TB] spurious response");
    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);

    $display("[TB] reset mid-flight");
    applyStimulus(1, 1, 1, 0, 32'h0);
    applyStimulus(1, 1, 2, 0, 32'h0);
    resetMidFlight();
    applyStimulus(0, 0, 0, 1, 32'h5555_AAAA);
    applyStimulus(0, 0, 0, 0, 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      logic r;
      logic g;
      logic v;
      r = 1'($urandom);
      g = r & 1'($urandom);
      v = ($urandom_range(0, 3) != 0) ? (owner_q.size() != 0) : 1'($urandom);
      applyStimulus(r, g, $urandom_range(0, MASTERS - 1), v, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_interconnect_rsp_router.md
Name: obi_interconnect_rsp_router

Overview:
- Per-slave response-path block of the OBI interconnect.
- Records which master owns each granted request to one slave, in order, in a small ID FIFO.
- Steers that slave's rvalid/rdata back to the owning master.
- Sits beside the per-slave master selector: the selector picks the request winner, this block returns the response; it throttles new grants when the outstanding limit is reached.

Parameters:
- MASTERS, 3, number of masters attached to this slave port
- MASTER_BITS, (MASTERS==1 ? 1 : $clog2(MASTERS)), width of master index
- OUTSTANDING, 2, max granted-but-unanswered transactions; power of two, >=1

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- master_sel_int_i  input  MASTER_BITS  index of master currently granted the slave (from selector)
- slave_req_i  input  1  request as driven to the slave
- slave_gnt_i  input  1  grant from the slave
- slave_rvalid_i  input  1  response valid from the slave
- slave_rdata_i  input  32  response data from the slave
- master_rvalid_o  output  1 [MASTERS]  per-master response valid
- master_rdata_o  output  32 [MASTERS]  per-master response data
- req_stall_o  output  1  high = outstanding limit reached; interconnect must mask slave_req
- outstanding_o  output  $clog2(OUTSTANDING+1)  current outstanding count

Behaviour:
- Single clock domain; clock clk_i; reset rst_ni, asynchronous, active-low.
- State: circular FIFO of OUTSTANDING entries of MASTER_BITS, write pointer, read pointer, count.
- Reset values: count=0, pointers=0, all entries=0, stall=0.
- push = slave_req_i & slave_gnt_i & ~req_stall_o. On push, store master_sel_int_i at wptr; wptr++ modulo OUTSTANDING.
- pop = slave_rvalid_i & (count!=0). On pop, rptr++ modulo OUTSTANDING.
- Count update: push only +1; pop only -1; both, unchanged.
- Response steering is combinational, zero latency from slave_rvalid_i:
  - master_rvalid_o[m] = pop & (fifo[rptr]==m).
  - master_rdata_o[m] = slave_rdata_i when master_rvalid_o[m], else 32'h0.
- OBI requires rvalid at least one cycle after gnt. A response in the same cycle as its own grant is never matched to that grant; only entries already in the FIFO are popped.
- req_stall_o = (count==OUTSTANDING); registered-state decode only, no combinational path from inputs.
- Full + rvalid in the same cycle: stall stays asserted this cycle (no pass-through); pop occurs, stall drops next cycle.
- Empty + rvalid: protocol violation. Dropped: no master_rvalid_o, count stays 0.
- gnt while stall: not pushed. Masking req is the interconnect's duty.
- Pointer wrap: at OUTSTANDING-1, next is 0. Order is strictly FIFO because OBI responses are in order.
- Reset mid-transaction: FIFO emptied immediately. Late responses after reset are treated as empty+rvalid (dropped).
- MASTERS==1: index width 1, entry always 0.

Optional Feature:
- Macro: OBI_RSP_ROUTER_ERR_EN.
- When defined:
  - Adds output err_o (1 bit), sticky, reset 0.
  - Set on empty+rvalid, or on gnt while req_stall_o.
  - Cleared only by reset.
  - Simulation-only assertion fires on the same conditions.
- When undefined: no err_o port, no error logic; the drop behaviour is unchanged.

Decomposition:
- Shared package obi_interconnect_pkg holds:
  - OBI_DATA_W=32 and OBI_ADDR_W=32 constants.
  - A function for index width from MASTERS, reused by the selector.
- One sub-module is natural: obi_id_fifo (parameterised width/depth FIFO with push/pop/count/full/empty).
- The router instantiates obi_id_fifo and adds the steering and stall logic.

Test Plan:
- Single read: MASTERS=3, master 2 granted cycle 0, rvalid cycle 2, rdata 32'hDEADBEEF -> master_rvalid_o[2]=1 with 32'hDEADBEEF in cycle 2; others rvalid 0, rdata 0; outstanding_o 1->0.
- Pipelined: grants to masters 1 then 0 in consecutive cycles (OUTSTANDING=2) -> req_stall_o=1 the cycle after the second grant; responses A then B go to master 1 then master 0.
- Full with simultaneous pop/gnt: count=2, rvalid and req&gnt together -> pop to head master, no push, count=1, stall low next cycle.
- Steady push/pop: one grant and one response every cycle for 8 cycles with master index pattern 0,1,2,... -> each response routed to the index granted one cycle earlier, count constant, pointers wrap without error.
- Spurious response: rvalid with count=0 -> no master_rvalid_o. With OBI_RSP_ROUTER_ERR_EN: err_o=1 next cycle and stays 1.
- Reset mid-flight: two outstanding, rst_ni low one cycle -> outstanding_o=0, req_stall_o=0 immediately; next rvalid dropped.
